// File: rtl/apu_sdm_rx.sv
// PWM / sigma-delta audio demodulator: counts high cycles per PWM frame, sums frame levels
// over a decimation period and emits saturated left-aligned PCM samples through a 2-entry FIFO.
module apu_sdm_rx #(
    parameter int unsigned W_SAMPLE   = 16,
    parameter int unsigned W_PWM      = 4,
    parameter int unsigned DECIM_LOG2 = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                d_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [W_SAMPLE-1:0] out_data_o,
    output logic                overflow_o,
    input  logic                ovf_clr_i
);

    localparam int unsigned W_SAT = W_PWM + DECIM_LOG2;
    localparam int unsigned W_ACC = W_SAT + 1;
    localparam int unsigned SHIFT = W_SAMPLE - W_SAT;

    logic [1:0]            sync_q;
    logic                  d_s;
    logic [W_PWM-1:0]      frame_cnt_q, frame_cnt_d;
    logic [W_PWM:0]        ones_q, ones_d;
    logic [DECIM_LOG2-1:0] frame_idx_q, frame_idx_d;
    logic [W_ACC-1:0]      sum_q, sum_d;

    logic [W_PWM:0]        level;
    logic [W_ACC-1:0]      total;
    logic [W_SAT-1:0]      sat;
    logic [W_SAMPLE-1:0]   sample;
    logic                  frame_end;
    logic                  last_frame;

    logic [W_SAMPLE-1:0]   mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  pop, push, full, ovf_set;

    assign d_s        = sync_q[1];
    assign level      = ones_q + {{W_PWM{1'b0}}, d_s};
    assign total      = sum_q + {{DECIM_LOG2{1'b0}}, level};
    // total never exceeds 2^W_SAT, so the top bit alone flags saturation.
    assign sat        = total[W_SAT] ? {W_SAT{1'b1}} : total[W_SAT-1:0];
    assign sample     = W_SAMPLE'(sat) << SHIFT;
    assign frame_end  = en_i && (&frame_cnt_q);
    assign last_frame = frame_end && (&frame_idx_q);

    always_comb begin
        frame_cnt_d = '0;
        ones_d      = '0;
        frame_idx_d = '0;
        sum_d       = '0;
        if (en_i) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            frame_idx_d = frame_idx_q;
            sum_d       = sum_q;
            if (frame_end) begin
                frame_idx_d = frame_idx_q + 1'b1;
                sum_d       = last_frame ? '0 : total;
            end else begin
                ones_d = level;
            end
        end
    end

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign overflow_o  = overflow_q;
    assign full        = count_q[1];
    assign pop         = out_valid_o && out_ready_i;
    // A pop on the same edge frees a slot, so a full buffer can still accept the push.
    assign push        = last_frame && (!full || pop);
    assign ovf_set     = last_frame && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            frame_cnt_q <= '0;
            ones_q      <= '0;
            frame_idx_q <= '0;
            sum_q       <= '0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], d_i};
            frame_cnt_q <= frame_cnt_d;
            ones_q      <= ones_d;
            frame_idx_q <= frame_idx_d;
            sum_q       <= sum_d;
            if (push) mem_q[wr_ptr_q] <= sample;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_apu_sdm_rx.sv
// Directed bench for apu_sdm_rx: DC/PWM levels, latency, backpressure, enable gating and reset.
module tb_apu_sdm_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        d = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int level = 0;
    int phase = 0;

    apu_sdm_rx #(
        .W_SAMPLE  (16),
        .W_PWM     (4),
        .DECIM_LOG2(6)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .d_i        (d),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .overflow_o (overflow),
        .ovf_clr_i  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs and sampling happen 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        d = (phase < level);
        phase = (phase + 1) % 16;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_valid(input string tag, input int c0, input int exp_cyc);
        int n = 0;
        while (!out_valid && n < 1100) begin
            tick();
            n++;
        end
        check_eq(tag, cyc - c0, exp_cyc);
    endtask

    // Hold en low with the new level long enough to fill the sync flops, then raise en.
    task automatic start(input int lvl, input int ph, output int c0);
        en = 1'b0;
        level = lvl;
        phase = ph;
        ticks(3);
        tick();
        en = 1'b1;
        c0 = cyc;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_level(input string tag, input int lvl, input int ph, input logic [15:0] exp);
        int c0;
        start(lvl, ph, c0);
        wait_valid({tag, "_lat"}, c0, 1024);
        pop_chk(tag, exp);
        check_eq({tag, "_empty"}, out_valid, 0);
    endtask

    initial begin
        int c0;

        ticks(3);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_ovf", overflow, 0);
        rst = 1'b0;
        ticks(2);

        start(16, 0, c0);
        wait_valid("dc1_lat", c0, 1024);
        pop_chk("dc1_s1", 16'hFFC0);
        wait_valid("dc1_period", c0, 2048);
        pop_chk("dc1_s2", 16'hFFC0);

        run_level("dc0", 0, 0, 16'h0000);
        run_level("lvl8", 8, 5, 16'h8000);
        run_level("lvl5", 5, 11, 16'h5000);
        run_level("lvl16", 16, 3, 16'hFFC0);

        start(3, 0, c0);
        ticks(509);
        level = 11;
        wait_valid("mix_lat", c0, 1024);
        pop_chk("mix", 16'h7000);

        // Three periods with no consumer: levels 2, 4, 6; the third sample is dropped.
        start(2, 7, c0);
        ticks(1021);
        level = 4;
        ticks(1024);
        level = 6;
        ticks(1026);
        check_eq("bp_pre_ovf", overflow, 0);
        check_eq("bp_full_valid", out_valid, 1);
        tick();
        check_eq("bp_ovf", overflow, 1);
        en = 1'b0;
        pop_chk("bp_s1", 16'h2000);
        pop_chk("bp_s2", 16'h4000);
        check_eq("bp_empty", out_valid, 0);
        check_eq("bp_ovf_kept", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("bp_ovf_clr", overflow, 0);

        // Pop on the very edge that pushes the third sample.
        start(2, 0, c0);
        ticks(1021);
        level = 4;
        ticks(1024);
        level = 6;
        ticks(1026);
        check_eq("pp_head", out_data, 16'h2000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("pp_ovf", overflow, 0);
        en = 1'b0;
        pop_chk("pp_s2", 16'h4000);
        pop_chk("pp_s3", 16'h6000);
        check_eq("pp_empty", out_valid, 0);

        // Clear pulse on the dropping edge: set must win.
        start(1, 0, c0);
        ticks(3071);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("ovf_set_wins", overflow, 1);
        en = 1'b0;
        pop_chk("sw_s1", 16'h1000);
        pop_chk("sw_s2", 16'h1000);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // en low mid-period: partial sum discarded, buffered sample still drains.
        start(9, 4, c0);
        wait_valid("en_s1_lat", c0, 1024);
        ticks(476);
        en = 1'b0;
        level = 3;
        pop_chk("en_drain", 16'h9000);
        check_eq("en_drain_empty", out_valid, 0);
        ticks(298);
        tick();
        en = 1'b1;
        c0 = cyc;
        wait_valid("en_lat", c0, 1024);
        pop_chk("en_s2", 16'h3000);

        // Reset with the buffer full and overflow set.
        start(16, 0, c0);
        ticks(3072);
        check_eq("pr_ovf", overflow, 1);
        check_eq("pr_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_ovf", overflow, 0);
        tick();
        tick();
        rst = 1'b0;
        c0 = cyc;
        // Sync flops restart at 0, so the first two cycles of the period count as low.
        wait_valid("post_rst_lat", c0, 1024);
        check_eq("post_rst_data", out_data, 16'hFF80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
